shift_reg_burst: RTL and testbench
==================================

// Module: shift_reg_burst
// PURPOSE
//   Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with
//   clock enable, parallel load, single-step shift/rotate and a counted burst-shift
//   engine (IDLE/SHIFT/DONE FSM) with busy/done status.
//   Used as a serialiser/deserialiser and test vehicle for interface-driven benches.
// PARAMETERS
//   WIDTH  8  data register width in bits (>=2)
//   LEN_W  4  width of burst length input; bursts of 0..2**LEN_W-1 shifts
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   rst    in   1      synchronous reset, active-high
//   en     in   1      clock enable; 0 freezes q, FSM and counter (except DONE exit)
//   load   in   1      parallel load request (IDLE only)
//   d      in   WIDTH  parallel load data
//   shift  in   1      single-step shift request (IDLE only)
//   start  in   1      burst start request (IDLE only)
//   len    in   LEN_W  burst length, sampled on start acceptance
//   dir    in   1      0 = left (toward MSB), 1 = right (toward LSB)
//   rot    in   1      0 = shift (sin enters), 1 = rotate (sin ignored)
//   sin    in   1      serial input, sampled live on every shift cycle
//   q      out  WIDTH  register contents
//   sout   out  1      combinational: dir=0 -> q[WIDTH-1], dir=1 -> q[0] (burst: latched dir)
//   busy   out  1      1 while FSM in SHIFT
//   done   out  1      1-cycle pulse, FSM in DONE
// BEHAVIOUR
//   - Reset: q=0, state=IDLE, count=0, busy=0, done=0, latched dir/rot=0.
//   - Priority in IDLE with en=1: load > start > shift > hold.
//     load: q<=d next edge. shift: one step per dir/rot/sin, 1-cycle latency.
//   - Step left: q<={q[WIDTH-2:0], rot?q[WIDTH-1]:sin}; right: {rot?q[0]:sin, q[WIDTH-1:1]}.
//   - start accepted at edge T: count<=len, dir/rot latched; state<=SHIFT if len!=0,
//     else DONE. No shift at edge T.
//   - SHIFT, en=1: one step per edge using latched dir/rot and live sin; count-=1;
//     count==1 at the edge -> DONE. en=0: nothing changes, stay SHIFT.
//   - Burst of len=N: shifts at edges T+1..T+N; done=1 during the cycle after T+N.
//   - DONE lasts exactly one clk cycle, then IDLE, regardless of en.
//   - load/shift/start while in SHIFT or DONE: ignored, no effect, no queueing.
//   - en=0 in IDLE: all requests ignored, q holds.
//   - rst at any time (incl. mid-burst): next edge full reset values, burst aborted,
//     no done pulse.
//   - Burst length may exceed WIDTH; shifting continues (q may become all-sin).
//   - count is LEN_W bits; never underflows (exits at 1).
// TESTING
//   1 rst=1 one edge with garbage inputs -> q=0x00, busy=0, done=0.
//   2 load=1 d=0xA5 -> q=0xA5; then shift=1 dir=0 rot=0 sin=1 -> q=0x4B; sout=1 before, 0 after.
//   3 q=0x81, start len=3 dir=1 rot=1 -> busy 3 cycles, q 0xC0,0x60,0x30; done one cycle; IDLE.
//   4 start len=0 -> next cycle done=1, busy never 1, q unchanged.
//   5 burst len=4 on 0x01 dir=0 rot=0 sin=0; en=0 for 2 cycles after 1st shift -> q holds 0x02,
//     busy held; final q=0x10, done 2 cycles later than unstalled.
//   6 load=1 d=0xFF mid-burst -> ignored; rst mid-burst -> q=0, busy=0, no done pulse.

Source files
------------

// File: rtl/shift_reg_burst.sv
// WIDTH-bit register with clock enable, parallel load, single-step shift/rotate
// and a counted burst-shift engine (IDLE/SHIFT/DONE) reporting busy/done.
module shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             dir,
    input  logic             rot,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: none; requests (load/shift/start) are level-sampled on a rising
    // edge and act only when the engine is IDLE with en=1, otherwise dropped.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] count, count_nx;
    logic             ldir, ldir_nx;
    logic             lrot, lrot_nx;
    logic [WIDTH-1:0] q_nx;

    logic             step_dir;
    logic             step_rot;
    logic             step_in;
    logic [WIDTH-1:0] stepped;

    // Outside IDLE the step direction/mode come from the values latched at start.
    always_comb begin
        step_dir = (state == S_IDLE) ? dir : ldir;
        step_rot = (state == S_IDLE) ? rot : lrot;
        if (step_dir) begin
            step_in = step_rot ? q[0] : sin;
            stepped = {step_in, q[WIDTH-1:1]};
        end else begin
            step_in = step_rot ? q[WIDTH-1] : sin;
            stepped = {q[WIDTH-2:0], step_in};
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        ldir_nx  = ldir;
        lrot_nx  = lrot;
        q_nx     = q;
        case (state)
            S_IDLE: begin
                if (en) begin
                    if (load) begin
                        q_nx = d;
                    end else if (start) begin
                        count_nx = len;
                        ldir_nx  = dir;
                        lrot_nx  = rot;
                        state_nx = (len != '0) ? S_SHIFT : S_DONE;
                    end else if (shift) begin
                        q_nx = stepped;
                    end
                end
            end
            S_SHIFT: begin
                if (en) begin
                    q_nx     = stepped;
                    count_nx = count - LEN_W'(1);
                    if (count == LEN_W'(1)) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            ldir  <= 1'b0;
            lrot  <= 1'b0;
            q     <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            ldir  <= ldir_nx;
            lrot  <= lrot_nx;
            q     <= q_nx;
        end
    end

    assign sout      = step_dir ? q[0] : q[WIDTH-1];
    assign busy      = (state == S_SHIFT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Bench for shift_reg_burst: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the register and burst engine.
module tb_shift_reg_burst;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst, en, load, shift, start, dir, rot, sin;
    logic [WIDTH-1:0] d;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] q;
    logic             sout, busy, done;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;

    // Model: register value, shifts still owed by a burst, one-cycle done flag.
    logic [WIDTH-1:0] m_q;
    int               m_rem;
    logic             m_busy, m_done, m_ldir, m_lrot;

    shift_reg_burst #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .shift(shift),
        .start(start), .len(len), .dir(dir), .rot(rot), .sin(sin), .q(q),
        .sout(sout), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v, input logic right,
                                                  input logic rt, input logic s);
        int unsigned x;
        int unsigned b;
        x = int'(v);
        if (right) begin
            b = rt ? (x % 2) : int'(s);
            return WIDTH'((x / 2) + b * (2 ** (WIDTH - 1)));
        end else begin
            b = rt ? (x / (2 ** (WIDTH - 1))) : int'(s);
            return WIDTH'(((x * 2) % (2 ** WIDTH)) + b);
        end
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_q = '0; m_rem = 0; m_busy = 0; m_done = 0; m_ldir = 0; m_lrot = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (en) begin
                m_q = step_val(m_q, m_ldir, m_lrot, sin);
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (en) begin
            if (load) begin
                m_q = d;
            end else if (start) begin
                m_ldir = dir;
                m_lrot = rot;
                m_rem  = int'(len);
                if (len == 0) m_done = 1;
                else m_busy = 1;
            end else if (shift) begin
                m_q = step_val(m_q, dir, rot, sin);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_sout;
        exp_sout = (m_busy || m_done) ? (m_ldir ? m_q[0] : m_q[WIDTH-1])
                                      : (dir ? m_q[0] : m_q[WIDTH-1]);
        check({tag, "_q"}, 32'(q), 32'(m_q));
        check({tag, "_busy"}, 32'(busy), 32'(m_busy));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_sout"}, 32'(sout), 32'(exp_sout));
    endtask

    task automatic idle_inputs();
        rst = 0; en = 1; load = 0; shift = 0; start = 0;
        d = '0; len = '0; dir = 0; rot = 0; sin = 0;
    endtask

    // One rising edge: model advances with the inputs the DUT sees, then compare.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        m_q = '0; m_rem = 0; m_busy = 0; m_done = 0; m_ldir = 0; m_lrot = 0;

        // 1: reset with garbage inputs
        idle_inputs();
        rst = 1; load = 1; d = 8'h5A; start = 1; len = 4'd7; shift = 1; sin = 1;
        tick("rst");
        check("rst_q0", 32'(q), 32'h00);
        idle_inputs();
        tick("post_rst");

        // 2: load then single left shift with sin=1
        load = 1; d = 8'hA5;
        tick("ld");
        idle_inputs();
        #1;
        check("t2_sout_before", 32'(sout), 32'd1);
        shift = 1; dir = 0; rot = 0; sin = 1;
        tick("sh");
        check("t2_q", 32'(q), 32'h4B);
        idle_inputs();
        #1;
        check("t2_sout_after", 32'(sout), 32'd0);

        // 3: rotate-right burst of 3 on 0x81
        load = 1; d = 8'h81;
        tick("ld3");
        idle_inputs();
        start = 1; len = 4'd3; dir = 1; rot = 1;
        tick("st3");
        idle_inputs();
        tick("b3_1"); check("t3_q1", 32'(q), 32'hC0); check("t3_busy1", 32'(busy), 32'd1);
        tick("b3_2"); check("t3_q2", 32'(q), 32'h60);
        tick("b3_3"); check("t3_q3", 32'(q), 32'h30); check("t3_done", 32'(done), 32'd1);
        tick("b3_4"); check("t3_idle", 32'(done | busy), 32'd0);

        // 4: zero-length burst
        start = 1; len = 4'd0;
        tick("st0");
        idle_inputs();
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_q", 32'(q), 32'h30);
        tick("b0_1");

        // 5: stalled burst of 4 on 0x01
        load = 1; d = 8'h01;
        tick("ld5");
        idle_inputs();
        start = 1; len = 4'd4;
        tick("st5");
        idle_inputs();
        tick("b5_1");
        en = 0;
        tick("b5_s1"); check("t5_hold1", 32'(q), 32'h02); check("t5_busy_s", 32'(busy), 32'd1);
        tick("b5_s2"); check("t5_hold2", 32'(q), 32'h02);
        en = 1;
        tick("b5_2");
        tick("b5_3"); check("t5_not_done", 32'(done), 32'd0);
        tick("b5_4"); check("t5_q", 32'(q), 32'h10); check("t5_done", 32'(done), 32'd1);
        tick("b5_5");

        // 6: load ignored mid-burst, then reset aborts the burst
        start = 1; len = 4'd6; dir = 0; rot = 1;
        tick("st6");
        idle_inputs();
        tick("b6_1");
        load = 1; d = 8'hFF;
        tick("b6_ld");
        check("t6_ld_ign", 32'(q == 8'hFF), 32'd0);
        idle_inputs();
        rst = 1;
        tick("b6_rst");
        check("t6_rst_q", 32'(q), 32'h00);
        rst = 0;
        tick("b6_after");
        check("t6_no_done", 32'(done), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            en    = ($urandom_range(0, 9) < 8);
            load  = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 7) == 0);
            shift = ($urandom_range(0, 2) == 0);
            d     = WIDTH'($urandom);
            len   = LEN_W'($urandom);
            dir   = 1'($urandom);
            rot   = 1'($urandom);
            sin   = 1'($urandom);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
